// File: rtl/jtdd_dwnld_buf.sv
// ROM download buffer: maps the ioctl byte stream onto SDRAM words through a 4-entry FIFO and a PROM port.
// Optional checksum accumulator enabled by defining JTDD_DWNLD_CKSUM_EN.
//  state | meaning
//  IDLE  | no SDRAM request outstanding; loads FIFO head when non-empty
//  ISSUE | prog_* valid and prog_we high until sdram_ack pops the head
module jtdd_dwnld_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        downloading,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  input  logic        ioctl_wr,
  input  logic        sdram_ack,
  output logic [21:0] prog_addr,
  output logic [7:0]  prog_data,
  output logic [1:0]  prog_mask,
  output logic        prog_we,
  output logic        prom_we,
  output logic [7:0]  prom_addr,
  output logic [3:0]  prom_data,
  output logic        dwnld_busy,
  output logic        overflow,
  output logic [15:0] cksum
);

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t      state, state_nx;
  logic        accept;
  logic        map_sdram, map_prom;
  logic [21:0] map_addr;
  logic [1:0]  map_mask;
  logic        push, push_ok, pop, ovf_set, load_head;
  logic        dl_q, clr;
  logic [31:0] fifo_mem [4];
  logic [1:0]  wr_ptr, rd_ptr, wr_idx;
  logic [2:0]  count;
  logic        fifo_empty, fifo_full;

  assign accept = ioctl_wr & downloading;

  always_comb begin
    map_sdram = 1'b0;
    map_prom  = 1'b0;
    map_addr  = '0;
    map_mask  = 2'b11;
    if (ioctl_addr < 25'h60000) begin
      map_sdram = 1'b1;
      map_addr  = ioctl_addr[22:1];
      map_mask  = ioctl_addr[0] ? 2'b01 : 2'b10;
    end else if (ioctl_addr < 25'h80000) begin
      map_sdram = 1'b1;
      map_addr  = 22'h60000 + {6'd0, ioctl_addr[15:0]};
      map_mask  = ioctl_addr[16] ? 2'b01 : 2'b10;
    end else if (ioctl_addr < 25'hC0000) begin
      map_sdram = 1'b1;
      map_addr  = 22'h80000 + {5'd0, ioctl_addr[16:0]};
      map_mask  = ioctl_addr[17] ? 2'b01 : 2'b10;
    end else if (ioctl_addr < 25'hC4000) begin
      map_sdram = 1'b1;
      map_addr  = 22'hC0000 + {8'd0, ioctl_addr[13:0]};
      map_mask  = 2'b10;
    end else if (ioctl_addr < 25'hC4100) begin
      map_prom  = 1'b1;
    end
  end

  assign fifo_empty = (count == 3'd0);
  assign fifo_full  = (count == 3'd4);
  assign push       = accept & map_sdram;
  assign push_ok    = push & (~fifo_full | pop);
  assign ovf_set    = push & fifo_full & ~pop;
  // Pointers may only restart when nothing is queued or in flight.
  assign clr        = downloading & ~dl_q & fifo_empty & (state == IDLE);
  assign wr_idx     = clr ? 2'd0 : wr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dl_q <= 1'b0;
    else        dl_q <= downloading;
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_idx] <= {map_addr, ioctl_data, map_mask};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= push_ok ? 2'd1 : 2'd0;
      count  <= push_ok ? 3'd1 : 3'd0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 2'd1;
      if (pop)     rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'd0, push_ok} - {2'd0, pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       overflow <= 1'b0;
    else if (clr)     overflow <= 1'b0;
    else if (ovf_set) overflow <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (!fifo_empty) state_nx = ISSUE;
      ISSUE:   if (sdram_ack)   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    prog_we   = (state == ISSUE);
    load_head = (state == IDLE) & ~fifo_empty;
    pop       = (state == ISSUE) & sdram_ack;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prog_addr <= '0;
      prog_data <= '0;
      prog_mask <= 2'b11;
    end else if (load_head) begin
      {prog_addr, prog_data, prog_mask} <= fifo_mem[rd_ptr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prom_we   <= 1'b0;
      prom_addr <= '0;
      prom_data <= '0;
    end else begin
      prom_we <= accept & map_prom;
      if (accept & map_prom) begin
        prom_addr <= ioctl_addr[7:0];
        prom_data <= ioctl_data[3:0];
      end
    end
  end

  assign dwnld_busy = downloading | ~fifo_empty | (state == ISSUE);

`ifdef JTDD_DWNLD_CKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cksum <= '0;
    else if (clr)    cksum <= accept ? {8'd0, ioctl_data} : 16'd0;
    else if (accept) cksum <= cksum + {8'd0, ioctl_data};
  end
`else
  assign cksum = 16'h0000;
`endif

endmodule

// File: tb/tb_jtdd_dwnld_buf.sv
// Directed bench for jtdd_dwnld_buf: address map table plus latency, overflow, reset and checksum sequences.
module tb_jtdd_dwnld_buf;

  logic        clk = 1'b0;
  logic        rst_n, downloading, ioctl_wr, sdram_ack;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic [21:0] prog_addr;
  logic [7:0]  prog_data;
  logic [1:0]  prog_mask;
  logic        prog_we, prom_we, dwnld_busy, overflow;
  logic [7:0]  prom_addr;
  logic [3:0]  prom_data;
  logic [15:0] cksum;

  jtdd_dwnld_buf dut (
    .clk(clk), .rst_n(rst_n), .downloading(downloading), .ioctl_addr(ioctl_addr),
    .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr), .sdram_ack(sdram_ack),
    .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask), .prog_we(prog_we),
    .prom_we(prom_we), .prom_addr(prom_addr), .prom_data(prom_data),
    .dwnld_busy(dwnld_busy), .overflow(overflow), .cksum(cksum)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dl;
    logic [24:0] a;
    logic [7:0]  d;
    logic        sd;
    logic [21:0] pa;
    logic [1:0]  pm;
    logic        pr;
    logic [7:0]  pra;
    logic [3:0]  prd;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  int checks = 0;
  int errors = 0;
  int n_wr;
  logic [21:0] cap_addr [8];
  logic [7:0]  cap_data [8];
  logic [1:0]  cap_mask [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(output int n);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      cap_addr[i] = '0; cap_data[i] = '0; cap_mask[i] = '0;
    end
    sdram_ack = 1'b1;
    for (int c = 0; c < 80 && dwnld_busy; c++) begin
      if (prog_we) begin
        if (n < 8) begin
          cap_addr[n] = prog_addr; cap_data[n] = prog_data; cap_mask[n] = prog_mask;
        end
        n++;
      end
      step();
    end
    sdram_ack = 1'b0;
    chk("drain_busy_fall", {31'd0, dwnld_busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    vecs[0]  = '{1'b1, 25'h0000003, 8'h5A, 1'b1, 22'h00001, 2'b01, 1'b0, 8'h00, 4'h0};
    vecs[1]  = '{1'b1, 25'h0000004, 8'h11, 1'b1, 22'h00002, 2'b10, 1'b0, 8'h00, 4'h0};
    vecs[2]  = '{1'b1, 25'h005FFFF, 8'h22, 1'b1, 22'h2FFFF, 2'b01, 1'b0, 8'h00, 4'h0};
    vecs[3]  = '{1'b1, 25'h0060000, 8'h33, 1'b1, 22'h60000, 2'b10, 1'b0, 8'h00, 4'h0};
    vecs[4]  = '{1'b1, 25'h0071234, 8'h77, 1'b1, 22'h61234, 2'b01, 1'b0, 8'h00, 4'h0};
    vecs[5]  = '{1'b1, 25'h007FFFF, 8'h88, 1'b1, 22'h6FFFF, 2'b01, 1'b0, 8'h00, 4'h0};
    vecs[6]  = '{1'b1, 25'h00A0010, 8'h44, 1'b1, 22'h80010, 2'b01, 1'b0, 8'h00, 4'h0};
    vecs[7]  = '{1'b1, 25'h0080001, 8'h55, 1'b1, 22'h80001, 2'b10, 1'b0, 8'h00, 4'h0};
    vecs[8]  = '{1'b1, 25'h00BFFFF, 8'h5B, 1'b1, 22'h9FFFF, 2'b01, 1'b0, 8'h00, 4'h0};
    vecs[9]  = '{1'b1, 25'h00C3FFF, 8'h66, 1'b1, 22'hC3FFF, 2'b10, 1'b0, 8'h00, 4'h0};
    vecs[10] = '{1'b1, 25'h00C4005, 8'h3C, 1'b0, 22'h00000, 2'b11, 1'b1, 8'h05, 4'hC};
    vecs[11] = '{1'b1, 25'h00C40FF, 8'hA7, 1'b0, 22'h00000, 2'b11, 1'b1, 8'hFF, 4'h7};
    vecs[12] = '{1'b1, 25'h00C4100, 8'h99, 1'b0, 22'h00000, 2'b11, 1'b0, 8'h00, 4'h0};
    vecs[13] = '{1'b1, 25'h1000000, 8'h12, 1'b0, 22'h00000, 2'b11, 1'b0, 8'h00, 4'h0};
    vecs[14] = '{1'b0, 25'h0000010, 8'h34, 1'b0, 22'h00000, 2'b11, 1'b0, 8'h00, 4'h0};

    rst_n = 1'b0; downloading = 1'b0; ioctl_wr = 1'b0; sdram_ack = 1'b0;
    ioctl_addr = '0; ioctl_data = '0;
    #12;
    chk("rst_prog_we",   {31'd0, prog_we}, 32'd0);
    chk("rst_prom_we",   {31'd0, prom_we}, 32'd0);
    chk("rst_prog_addr", {10'd0, prog_addr}, 32'd0);
    chk("rst_prog_data", {24'd0, prog_data}, 32'd0);
    chk("rst_prog_mask", {30'd0, prog_mask}, 32'd3);
    chk("rst_prom_addr", {24'd0, prom_addr}, 32'd0);
    chk("rst_prom_data", {28'd0, prom_data}, 32'd0);
    chk("rst_overflow",  {31'd0, overflow}, 32'd0);
    chk("rst_cksum",     {16'd0, cksum}, 32'd0);
    chk("rst_busy_lo",   {31'd0, dwnld_busy}, 32'd0);
    downloading = 1'b1;
    #1;
    chk("rst_busy_hi",   {31'd0, dwnld_busy}, 32'd1);
    #9 rst_n = 1'b1;
    step();

    // address map table: one byte, then observe PROM and SDRAM sides
    for (int i = 0; i < NV; i++) begin
      downloading = vecs[i].dl;
      ioctl_addr  = vecs[i].a;
      ioctl_data  = vecs[i].d;
      ioctl_wr    = 1'b1;
      step();
      ioctl_wr = 1'b0;
      downloading = 1'b1;
      chk($sformatf("v%0d_prom_we", i), {31'd0, prom_we}, {31'd0, vecs[i].pr});
      if (vecs[i].pr) begin
        chk($sformatf("v%0d_prom_addr", i), {24'd0, prom_addr}, {24'd0, vecs[i].pra});
        chk($sformatf("v%0d_prom_data", i), {28'd0, prom_data}, {28'd0, vecs[i].prd});
      end
      step();
      chk($sformatf("v%0d_prom_we_1cyc", i), {31'd0, prom_we}, 32'd0);
      chk($sformatf("v%0d_prog_we", i), {31'd0, prog_we}, {31'd0, vecs[i].sd});
      if (vecs[i].sd) begin
        chk($sformatf("v%0d_prog_addr", i), {10'd0, prog_addr}, {10'd0, vecs[i].pa});
        chk($sformatf("v%0d_prog_data", i), {24'd0, prog_data}, {24'd0, vecs[i].d});
        chk($sformatf("v%0d_prog_mask", i), {30'd0, prog_mask}, {30'd0, vecs[i].pm});
        sdram_ack = 1'b1;
        step();
        sdram_ack = 1'b0;
        chk($sformatf("v%0d_prog_we_done", i), {31'd0, prog_we}, 32'd0);
      end
    end

    // ack two cycles after prog_we rises: request held for three cycles
    ioctl_addr = 25'h0000003; ioctl_data = 8'h5A; ioctl_wr = 1'b1;
    step();
    ioctl_wr = 1'b0;
    step();
    hi = 0;
    for (int c = 0; c < 6; c++) begin
      if (prog_we) hi++;
      if (c == 2) begin
        chk("hold_addr", {10'd0, prog_addr}, 32'h1);
        chk("hold_data", {24'd0, prog_data}, 32'h5A);
        chk("hold_mask", {30'd0, prog_mask}, 32'h1);
      end
      sdram_ack = (c == 2);
      step();
    end
    sdram_ack = 1'b0;
    chk("we_cycles", hi, 32'd3);

    // six back-to-back bytes with no ack: four stored, overflow set
    for (int i = 0; i < 6; i++) begin
      ioctl_addr = 25'(i); ioctl_data = 8'h10 + 8'(i); ioctl_wr = 1'b1;
      step();
    end
    ioctl_wr = 1'b0;
    chk("ovf_set", {31'd0, overflow}, 32'd1);
    downloading = 1'b0;
    drain(n_wr);
    chk("ovf_writes", n_wr, 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ovf_addr%0d", i), {10'd0, cap_addr[i]}, 32'(i / 2));
      chk($sformatf("ovf_data%0d", i), {24'd0, cap_data[i]}, 32'h10 + 32'(i));
      chk($sformatf("ovf_mask%0d", i), {30'd0, cap_mask[i]}, (i % 2 == 1) ? 32'd1 : 32'd2);
    end
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);
    downloading = 1'b1;
    step();
    chk("ovf_clear_on_rise", {31'd0, overflow}, 32'd0);

    // full FIFO with push and pop in the same cycle: push accepted
    for (int i = 0; i < 4; i++) begin
      ioctl_addr = 25'h100 + 25'(i); ioctl_data = 8'h20 + 8'(i); ioctl_wr = 1'b1;
      step();
    end
    ioctl_addr = 25'h104; ioctl_data = 8'h24; ioctl_wr = 1'b1; sdram_ack = 1'b1;
    step();
    ioctl_wr = 1'b0; sdram_ack = 1'b0;
    chk("pushpop_no_ovf", {31'd0, overflow}, 32'd0);
    downloading = 1'b0;
    drain(n_wr);
    chk("pushpop_writes", n_wr, 32'd4);
    chk("pushpop_first_addr", {10'd0, cap_addr[0]}, 32'h80);
    chk("pushpop_last_addr",  {10'd0, cap_addr[3]}, 32'h82);
    chk("pushpop_last_data",  {24'd0, cap_data[3]}, 32'h24);
    chk("pushpop_last_mask",  {30'd0, cap_mask[3]}, 32'd2);

    // reset asserted mid-ISSUE
    downloading = 1'b1;
    ioctl_addr = 25'h200; ioctl_data = 8'h5E; ioctl_wr = 1'b1;
    step();
    ioctl_wr = 1'b0;
    step();
    chk("rstmid_issue", {31'd0, prog_we}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_we_async", {31'd0, prog_we}, 32'd0);
    chk("rstmid_mask",     {30'd0, prog_mask}, 32'd3);
    chk("rstmid_busy_dl",  {31'd0, dwnld_busy}, 32'd1);
    downloading = 1'b0;
    #1;
    chk("rstmid_busy_lo",  {31'd0, dwnld_busy}, 32'd0);
    #3 rst_n = 1'b1;
    hi = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (prog_we || dwnld_busy) hi++;
    end
    chk("rstmid_no_resume", hi, 32'd0);

    // checksum over dropped-range bytes
    step();
    downloading = 1'b1;
    step();
    ioctl_addr = 25'hC4100; ioctl_wr = 1'b1;
    ioctl_data = 8'hFF; step();
    ioctl_data = 8'hFF; step();
    ioctl_data = 8'h03; step();
    ioctl_wr = 1'b0;
    step();
    chk("cksum_drop_no_we", {31'd0, prog_we}, 32'd0);
`ifdef JTDD_DWNLD_CKSUM_EN
    chk("cksum_value", {16'd0, cksum}, 32'h0201);
`else
    chk("cksum_value", {16'd0, cksum}, 32'h0000);
`endif
    downloading = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
